// File: rtl/md_unit_if.sv
// Execute-stage bus between the pipeline controller and the multiply/divide unit.
interface md_unit_if #(parameter int WIDTH = 32);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Sign;
  logic [1:0]       MDFun;
  logic             start;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (output A, B, Sign, MDFun, start, input busy, done, HI, LO);
  modport slave  (input A, B, Sign, MDFun, start, output busy, done, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Iterative 32-cycle multiply/divide unit with HI/LO registers.
// Define MD_UNIT_DIV_EN to include the restoring divider; otherwise DIV requests are ignored.
module md_unit #(parameter int WIDTH = 32) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  md
);
  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t             state;
  logic [4:0]         cnt;
  logic [2*WIDTH-1:0] acc;   // mul: {partial, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   opr;   // mul: |multiplicand|; div: |divisor|
  logic               neg;   // product / quotient sign
  logic               busy_r, done_r;
  logic [WIDTH-1:0]   hi, lo;

  logic               sa, sb;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    sa      = md.Sign & md.A[WIDTH-1];
    sb      = md.Sign & md.B[WIDTH-1];
    a_mag   = sa ? -md.A : md.A;
    b_mag   = sb ? -md.B : md.B;
    mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opr} : '0);
    prod    = neg ? -acc : acc;
  end

`ifdef MD_UNIT_DIV_EN
  logic             op_div, neg_r, dz;
  logic [WIDTH-1:0] a_raw;
  logic [WIDTH:0]   rem_sh;
  logic             ge;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  always_comb begin
    rem_sh  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    ge      = rem_sh >= {1'b0, opr};
    quo_fix = neg   ? -acc[WIDTH-1:0]       : acc[WIDTH-1:0];
    rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      opr    <= '0;
      neg    <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      hi     <= '0;
      lo     <= '0;
`ifdef MD_UNIT_DIV_EN
      op_div <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      a_raw  <= '0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: if (md.start) begin
          case (md.MDFun)
            2'b00: begin
              acc    <= {{WIDTH{1'b0}}, b_mag};
              opr    <= a_mag;
              neg    <= sa ^ sb;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= CALC;
`ifdef MD_UNIT_DIV_EN
              op_div <= 1'b0;
`endif
            end
`ifdef MD_UNIT_DIV_EN
            2'b01: begin
              acc    <= {{WIDTH{1'b0}}, a_mag};
              opr    <= b_mag;
              neg    <= sa ^ sb;
              neg_r  <= sa;
              dz     <= (md.B == '0);
              a_raw  <= md.A;
              op_div <= 1'b1;
              cnt    <= '0;
              busy_r <= 1'b1;
              state  <= CALC;
            end
`endif
            2'b10:   hi <= md.A;
            2'b11:   lo <= md.A;
            default: ;
          endcase
        end
        CALC: begin
`ifdef MD_UNIT_DIV_EN
          if (op_div)
            acc <= ge ? {rem_sh[WIDTH-1:0] - opr, acc[WIDTH-2:0], 1'b1}
                      : {rem_sh[WIDTH-1:0],       acc[WIDTH-2:0], 1'b0};
          else
`endif
            acc <= {mul_sum, acc[WIDTH-1:1]};
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) state <= FIX;
        end
        FIX: begin
`ifdef MD_UNIT_DIV_EN
          if (op_div) begin
            // Divide by zero reports the raw dividend, not the sign-corrected one.
            hi <= dz ? a_raw : rem_fix;
            lo <= dz ? '1    : quo_fix;
          end else
`endif
            {hi, lo} <= prod;
          busy_r <= 1'b0;
          done_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_r;
  assign md.done = done_r;
  assign md.HI   = hi;
  assign md.LO   = lo;
endmodule

// File: tb/tb_md_unit.sv
// Randomized self-checking bench for md_unit against an arithmetic HI/LO model.
module tb_md_unit;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] m_hi = '0, m_lo = '0;

  md_unit_if #(.WIDTH(32)) bus ();
  md_unit #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .md(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // {HI,LO} expected from the architectural definition.
  function automatic logic [63:0] model(input logic [1:0] fun, input logic sg,
                                        input logic [31:0] a, input logic [31:0] b);
    longint x, y, q, r;
    logic [63:0] p;
    x = sg ? longint'($signed(a)) : longint'({32'b0, a});
    y = sg ? longint'($signed(b)) : longint'({32'b0, b});
    if (fun == 2'b00) begin
      p = 64'(x * y);
      return p;
    end
    if (b == 32'b0) return {a, 32'hFFFFFFFF};
    q = x / y;
    r = x % y;
    return {r[31:0], q[31:0]};
  endfunction

  // inj_kind: 0 none, 1 MTLO pulse at cycle inj_cyc, 2 reset pulse at cycle inj_cyc.
  task automatic run_op(input logic [1:0] fun, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, input int inj_cyc, input int inj_kind);
    logic [63:0] exp;
    int n;
    bit held;
    exp = model(fun, sg, a, b);
    bus.start = 1'b1; bus.MDFun = fun; bus.Sign = sg; bus.A = a; bus.B = b;
    step();
    bus.start = 1'b0;
    bus.A = $urandom; bus.B = $urandom; bus.Sign = 1'($urandom); bus.MDFun = 2'($urandom);
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    n = 1;
    held = 1'b1;
    while (bus.busy === 1'b1 && n < 40) begin
      if (bus.HI !== m_hi || bus.LO !== m_lo || bus.done !== 1'b0) held = 1'b0;
      if (n == inj_cyc && inj_kind == 1) begin
        bus.start = 1'b1; bus.MDFun = 2'b11; bus.A = 32'hA5A5A5A5;
        step();
        bus.start = 1'b0;
      end else if (n == inj_cyc && inj_kind == 2) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        chk("abort_busy", 64'(bus.busy), 64'd0);
        chk("abort_done", 64'(bus.done), 64'd0);
        chk("abort_hilo", {bus.HI, bus.LO}, 64'd0);
        return;
      end else begin
        step();
      end
      if (bus.busy === 1'b1) n++;
    end
    chk("busy_cycles", 64'(n), 64'd33);
    chk("hilo_held", 64'(held), 64'd1);
    chk("done_pulse", 64'(bus.done), 64'd1);
    chk("result_hilo", {bus.HI, bus.LO}, exp);
    {m_hi, m_lo} = exp;
  endtask

  task automatic run_mt(input logic hi_sel, input logic [31:0] a);
    bus.start = 1'b1; bus.MDFun = {1'b1, ~hi_sel}; bus.A = a;
    step();
    bus.start = 1'b0;
    if (hi_sel) m_hi = a; else m_lo = a;
    chk("mt_hilo", {bus.HI, bus.LO}, {m_hi, m_lo});
    chk("mt_busy", 64'({bus.busy, bus.done}), 64'd0);
  endtask

  task automatic run_div_ignored(input logic [31:0] a, input logic [31:0] b);
    bit quiet;
    bus.start = 1'b1; bus.MDFun = 2'b01; bus.Sign = 1'b1; bus.A = a; bus.B = b;
    step();
    bus.start = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 35; i++) begin
      if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.HI !== m_hi || bus.LO !== m_lo) quiet = 1'b0;
      step();
    end
    chk("div_ignored", 64'(quiet), 64'd1);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.A = '0; bus.B = '0; bus.Sign = 1'b0; bus.MDFun = 2'b00;
    step(); step();
    chk("reset_busy", 64'(bus.busy), 64'd0);
    chk("reset_done", 64'(bus.done), 64'd0);
    chk("reset_hilo", {bus.HI, bus.LO}, 64'd0);
    reset = 1'b1;
    step();

    run_op(2'b00, 1'b1, 32'hFFFFFFFD, 32'd5, 0, 0);
    chk("mult_neg3x5", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(2'b00, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    chk("multu_max", {bus.HI, bus.LO}, 64'hFFFFFFFE_00000001);
`ifdef MD_UNIT_DIV_EN
    run_op(2'b01, 1'b1, 32'hFFFFFFF9, 32'd2, 0, 0);
    chk("div_neg7by2", {bus.HI, bus.LO}, 64'hFFFFFFFF_FFFFFFFD);
    run_op(2'b01, 1'b1, 32'h1234, 32'd0, 0, 0);
    chk("div_by_zero", {bus.HI, bus.LO}, 64'h00001234_FFFFFFFF);
    run_op(2'b01, 1'b1, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    chk("div_overflow", {bus.HI, bus.LO}, 64'h00000000_80000000);
`else
    run_div_ignored(32'hFFFFFFF9, 32'd2);
`endif
    step();
    run_mt(1'b1, 32'hDEADBEEF);
    run_mt(1'b0, 32'h0BADF00D);
    chk("mt_pair", {bus.HI, bus.LO}, 64'hDEADBEEF_0BADF00D);

    run_op(2'b00, 1'b0, 32'h00010001, 32'h00000003, 10, 1);
    chk("mtlo_ignored", 64'(bus.LO), 64'h00030003);
    run_op(2'b00, 1'b1, 32'h12345678, 32'h9ABCDEF0, 15, 2);
    run_op(2'b00, 1'b0, 32'd6, 32'd7, 0, 0);
    chk("mult_6x7", 64'(bus.LO), 64'd42);

    for (int i = 0; i < 30; i++) begin
      int k;
      k = $urandom_range(0, 3);
      case (k)
        0: run_op(2'b00, 1'($urandom), pick(), pick(), 0, 0);
`ifdef MD_UNIT_DIV_EN
        1: run_op(2'b01, 1'($urandom), pick(), pick(), 0, 0);
`else
        1: run_div_ignored(pick(), pick());
`endif
        2: run_mt(1'b1, $urandom);
        default: run_mt(1'b0, $urandom);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Iterative multiply/divide unit with architectural HI/LO registers, placed in the execute stage beside the ALU. It takes the same A/B operands and Sign flag the ALU uses and serves MULT/MULTU/DIV/DIVU/MTHI/MTLO. It produces HI/LO for MFHI/MFLO through the ALU result mux. It raises `busy` so the controller can stall while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, 32: operand and HI/LO width. Only 32 is supported; the parameter exists for readability.
- `clk`  in  1  single clock. All state updates on the rising edge.
- `reset`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `A`  in  32  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- `B`  in  32  rt operand: multiplier or divisor.
- `Sign`  in  1  1 = signed (MULT/DIV), 0 = unsigned (MULTU/DIVU). Ignored for MTHI/MTLO.
- `MDFun`  in  2  operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
- `start`  in  1  operation request, one cycle. Accepted only when `busy`=0.
- `busy`  out  1  a multiply or divide is in progress.
- `done`  out  1  one-cycle pulse in the cycle HI/LO first show a new mul/div result.
- `HI`  out  32  HI register.
- `LO`  out  32  LO register.

## Operation
- Reset values: state IDLE, `busy`=0, `done`=0, `HI`=0, `LO`=0, iteration counter 0.
- Reset mid-operation aborts the operation. Partial results are discarded and HI/LO are cleared.
- States:
  - IDLE:
    - `start`=1 with MDFun 10/11 writes A into HI or LO at that edge and stays in IDLE. `busy` and `done` are not raised.
    - `start`=1 with MDFun 00/01 latches |A|, |B| (magnitude only if Sign=1), the result-sign flags, and the op, then goes to CALC.
  - CALC: 32 iterations, one bit per cycle, counter 0..31. After iteration 31, goes to FIX.
    - Multiply: radix-2 shift-add into a 64-bit accumulator.
    - Divide: restoring shift-subtract, producing a 32-bit quotient and remainder.
  - FIX: applies two's-complement sign correction, writes HI/LO, and returns to IDLE. `done`=1 in the following cycle.
- Result rules:
  - Multiply: {HI,LO} = full 64-bit product. Negated if Sign=1 and A[31]^B[31].
  - Divide: LO = quotient, HI = remainder. With Sign=1, the quotient is negative iff the operand signs differ, and the remainder takes the dividend's sign.
  - Divide by zero, either Sign: HI = A, LO = 32'hFFFFFFFF, with the full normal latency.
  - Signed 32'h80000000 / 32'hFFFFFFFF: LO = 32'h80000000, HI = 0. No trap.
- `start` while `busy`=1 is ignored for every MDFun, including MTHI/MTLO. It is not queued.
- Operands are sampled only at acceptance. A/B/Sign/MDFun may change during CALC without effect.
- HI/LO hold their old values throughout CALC and FIX until the write edge.

## Timing
- `start` accepted at edge t:
  - `busy`=1 from after edge t through after edge t+32 (33 cycles).
  - HI/LO are updated at edge t+33. `done`=1 and `busy`=0 for the cycle after edge t+33.
- A new `start` is legal in the same cycle `done`=1. It is accepted at edge t+34.
- MTHI/MTLO: HI/LO are visible the cycle after the accepting edge. Latency 1, no `busy`.
- HI/LO are driven directly from registers, with no combinational path from inputs.

## Configuration
- `MD_UNIT_DIV_EN` defined: divide datapath present, behaviour as above.
- `MD_UNIT_DIV_EN` undefined:
  - Divider logic is removed.
  - `start` with MDFun=01 is ignored: no state change, `busy`/`done` stay 0, HI/LO unchanged.
  - MULT, MTHI and MTLO are unaffected.

## Test plan
- MULT, Sign=1, A=32'hFFFFFFFD (-3), B=5 -> after 33 busy cycles, `done` pulse, HI=32'hFFFFFFFF, LO=32'hFFFFFFF1.
- MULT, Sign=0, A=B=32'hFFFFFFFF -> HI=32'hFFFFFFFE, LO=32'h00000001.
- DIV, Sign=1, A=32'hFFFFFFF9 (-7), B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. Then DIV with A=32'h1234, B=0 -> HI=32'h1234, LO=32'hFFFFFFFF.
- MTHI A=32'hDEADBEEF, then MTLO A=32'h0BADF00D on consecutive cycles -> HI/LO show those values one cycle after each. `busy` stays 0.
- MULT in flight, then `start` MTLO pulsed at cycle 10 -> ignored. LO afterwards equals the product's low word only.
- MULT in flight, then `reset`=0 at cycle 15 for one cycle -> next cycle `busy`=0, `done`=0, HI=LO=0. A following MULT 6*7 gives LO=42.
